// File: rtl/filter_avalon_pkg.sv
// Shared register map, fp16 constants and master state encoding
// for the Madgwick filter Avalon slave and its hardware initiator.
package filter_avalon_pkg;

    localparam logic [7:0] ADDR_ACCELX = 8'd0;
    localparam logic [7:0] ADDR_ACCELY = 8'd4;
    localparam logic [7:0] ADDR_ACCELZ = 8'd8;
    localparam logic [7:0] ADDR_GYROX  = 8'd12;
    localparam logic [7:0] ADDR_GYROY  = 8'd16;
    localparam logic [7:0] ADDR_GYROZ  = 8'd20;
    localparam logic [7:0] ADDR_BETA   = 8'd24;
    localparam logic [7:0] ADDR_PERIOD = 8'd28;
    localparam logic [7:0] ADDR_OUTW   = 8'd56;
    localparam logic [7:0] ADDR_OUTI   = 8'd60;
    localparam logic [7:0] ADDR_OUTJ   = 8'd64;
    localparam logic [7:0] ADDR_OUTK   = 8'd68;
    localparam logic [7:0] ADDR_STATUS = 8'd72;
    localparam logic [7:0] ADDR_RUN    = 8'd76;

    localparam logic [15:0] FP16_ONE       = 16'h3C00;
    localparam logic [15:0] FP16_ZERO      = 16'h0000;
    localparam logic [15:0] BETA_DEFAULT   = 16'h27AE;
    localparam logic [15:0] PERIOD_DEFAULT = 16'h23AE;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_WR,
        ST_IDLE,
        ST_WR,
        ST_WR_RUN,
        ST_KICK,
        ST_RD_ISSUE,
        ST_RD_CAP
    } master_state_t;

    function automatic logic [7:0] sensor_addr(input logic [2:0] idx);
        return ADDR_ACCELX + {3'b0, idx, 2'b00};
    endfunction

    function automatic logic [7:0] out_addr(input logic [2:0] idx);
        return ADDR_OUTW + {3'b0, idx, 2'b00};
    endfunction

    function automatic logic [15:0] sample_slice(
        input logic [95:0] s,
        input logic [2:0]  idx
    );
        return s[int'(idx)*16 +: 16];
    endfunction

endpackage

// File: rtl/filter_avalon_txn.sv
// Single Avalon-MM access engine: registered strobes, waitrequest
// absorption, and read data returned one cycle after completion.
module filter_avalon_txn
    import filter_avalon_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_rnw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic              o_done,
    output logic              o_rvalid,
    output logic [15:0]       o_rdata,
    output logic [ADDR_W-1:0] o_av_address,
    output logic              o_av_chipselect,
    output logic              o_av_write,
    output logic              o_av_read,
    output logic [31:0]       o_av_writedata,
    output logic [3:0]        o_av_byteenable,
    input  logic [31:0]       i_av_readdata,
    input  logic              i_av_waitrequest
);

    logic              r_cs;
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_rvalid;
    logic              w_done;
    logic              w_unused_rd_hi;

    assign w_done         = r_cs & ~i_av_waitrequest;
    assign w_unused_rd_hi = ^i_av_readdata[31:16];

    // A new request may be loaded in the same edge the current one completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs     <= 1'b0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_done & r_rd;
            if (i_req) begin
                r_cs    <= 1'b1;
                r_wr    <= ~i_rnw;
                r_rd    <= i_rnw;
                r_addr  <= i_addr;
                r_wdata <= i_rnw ? 16'h0 : i_wdata;
            end else if (w_done) begin
                r_cs <= 1'b0;
                r_wr <= 1'b0;
                r_rd <= 1'b0;
            end
        end
    end

    assign o_done          = w_done;
    assign o_rvalid        = r_rvalid;
    assign o_rdata         = i_av_readdata[15:0];
    assign o_av_address    = r_addr;
    assign o_av_chipselect = r_cs;
    assign o_av_write      = r_wr;
    assign o_av_read       = r_rd;
    assign o_av_writedata  = {16'b0, r_wdata};
    assign o_av_byteenable = 4'hF;

endmodule

// File: rtl/filter_avalon_master.sv
// Sample-to-quaternion sequencer for the filter Avalon slave.
// Define FILTER_MASTER_INIT_EN to write BETA/PERIOD after reset.
module filter_avalon_master
    import filter_avalon_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter logic [15:0] BETA_INIT   = 16'h27AE,
    parameter logic [15:0] PERIOD_INIT = 16'h23AE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [95:0]       s_sample,
    output logic              q_valid,
    output logic [15:0]       q_w,
    output logic [15:0]       q_i,
    output logic [15:0]       q_j,
    output logic [15:0]       q_k,
    output logic              busy,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_chipselect,
    output logic              av_write,
    output logic              av_read,
    output logic [31:0]       av_writedata,
    output logic [3:0]        av_byteenable,
    input  logic [31:0]       av_readdata,
    input  logic              av_waitrequest
);

`ifdef FILTER_MASTER_INIT_EN
    localparam master_state_t RESET_STATE = ST_INIT;
`else
    localparam master_state_t RESET_STATE = ST_IDLE;
    localparam logic [31:0] unused_init_params = {BETA_INIT, PERIOD_INIT};
`endif
    localparam logic RESET_READY = (RESET_STATE == ST_IDLE);

    master_state_t r_state;
    master_state_t w_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_n;
    logic [95:0]   r_sample;
    logic          r_ready;
    logic          r_busy;
    logic          r_q_valid;
    logic [15:0]   r_q_w;
    logic [15:0]   r_q_i;
    logic [15:0]   r_q_j;
    logic [15:0]   r_q_k;

    logic              w_req;
    logic              w_rnw;
    logic [7:0]        w_reg;
    logic [15:0]       w_wdata;
    logic              w_accept;
    logic              w_cap;
    logic              w_qv_n;
    logic              w_done;
    logic              w_rvalid;
    logic [15:0]       w_rdata;
    logic [ADDR_W-1:0] w_addr;

    assign w_addr = ADDR_W'(w_reg);

    always_comb begin
        w_next   = r_state;
        w_idx_n  = r_idx;
        w_req    = 1'b0;
        w_rnw    = 1'b0;
        w_reg    = 8'd0;
        w_wdata  = 16'd0;
        w_accept = 1'b0;
        w_cap    = 1'b0;
        w_qv_n   = 1'b0;
        unique case (r_state)
`ifdef FILTER_MASTER_INIT_EN
            ST_INIT: begin
                w_next  = ST_INIT_WR;
                w_idx_n = 3'd0;
                w_req   = 1'b1;
                w_reg   = ADDR_BETA;
                w_wdata = BETA_INIT;
            end
            ST_INIT_WR: begin
                if (w_done) begin
                    if (r_idx == 3'd0) begin
                        w_idx_n = 3'd1;
                        w_req   = 1'b1;
                        w_reg   = ADDR_PERIOD;
                        w_wdata = PERIOD_INIT;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (s_valid) begin
                    // Sample register loads this edge, so slice 0 comes straight from the port.
                    w_accept = 1'b1;
                    w_next   = ST_WR;
                    w_idx_n  = 3'd0;
                    w_req    = 1'b1;
                    w_reg    = sensor_addr(3'd0);
                    w_wdata  = s_sample[15:0];
                end
            end
            ST_WR: begin
                if (w_done) begin
                    w_req = 1'b1;
                    if (r_idx == 3'd5) begin
                        w_next  = ST_WR_RUN;
                        w_reg   = ADDR_RUN;
                        w_wdata = 16'd1;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                        w_reg   = sensor_addr(w_idx_n);
                        w_wdata = sample_slice(r_sample, w_idx_n);
                    end
                end
            end
            ST_WR_RUN: begin
                if (w_done) begin
                    w_next = ST_KICK;
                    w_req  = 1'b1;
                    w_rnw  = 1'b1;
                    w_reg  = ADDR_STATUS;
                end
            end
            ST_KICK: begin
                if (w_done) begin
                    w_next  = ST_RD_ISSUE;
                    w_idx_n = 3'd0;
                    w_req   = 1'b1;
                    w_rnw   = 1'b1;
                    w_reg   = out_addr(3'd0);
                end
            end
            ST_RD_ISSUE: begin
                if (w_done) begin
                    w_next = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                w_cap = w_rvalid;
                if (r_idx == 3'd3) begin
                    w_next = ST_IDLE;
                    w_qv_n = 1'b1;
                end else begin
                    w_next  = ST_RD_ISSUE;
                    w_idx_n = r_idx + 3'd1;
                    w_req   = 1'b1;
                    w_rnw   = 1'b1;
                    w_reg   = out_addr(w_idx_n);
                end
            end
            default: begin
                w_next = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_idx     <= 3'd0;
            r_sample  <= '0;
            r_ready   <= RESET_READY;
            r_busy    <= ~RESET_READY;
            r_q_valid <= 1'b0;
            r_q_w     <= FP16_ZERO;
            r_q_i     <= FP16_ZERO;
            r_q_j     <= FP16_ZERO;
            r_q_k     <= FP16_ZERO;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx_n;
            r_ready   <= (w_next == ST_IDLE);
            r_busy    <= (w_next != ST_IDLE);
            r_q_valid <= w_qv_n;
            if (w_accept) begin
                r_sample <= s_sample;
            end
            if (w_cap) begin
                unique case (r_idx)
                    3'd0:    r_q_w <= w_rdata;
                    3'd1:    r_q_i <= w_rdata;
                    3'd2:    r_q_j <= w_rdata;
                    default: r_q_k <= w_rdata;
                endcase
            end
        end
    end

    filter_avalon_txn #(
        .ADDR_W (ADDR_W)
    ) u_txn (
        .clk              (clk),
        .reset            (reset),
        .i_req            (w_req),
        .i_rnw            (w_rnw),
        .i_addr           (w_addr),
        .i_wdata          (w_wdata),
        .o_done           (w_done),
        .o_rvalid         (w_rvalid),
        .o_rdata          (w_rdata),
        .o_av_address     (av_address),
        .o_av_chipselect  (av_chipselect),
        .o_av_write       (av_write),
        .o_av_read        (av_read),
        .o_av_writedata   (av_writedata),
        .o_av_byteenable  (av_byteenable),
        .i_av_readdata    (av_readdata),
        .i_av_waitrequest (av_waitrequest)
    );

    assign s_ready = r_ready;
    assign busy    = r_busy;
    assign q_valid = r_q_valid;
    assign q_w     = r_q_w;
    assign q_i     = r_q_i;
    assign q_j     = r_q_j;
    assign q_k     = r_q_k;

endmodule

// File: tb/tb_filter_avalon_master.sv
// Directed bench for filter_avalon_master with a 1-cycle-latency
// slave model and optional waitrequest on the RUN write.
module tb_filter_avalon_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [95:0] s_sample = '0;
    logic        q_valid;
    logic [15:0] q_w, q_i, q_j, q_k;
    logic        busy;
    logic [15:0] av_address;
    logic        av_chipselect, av_write, av_read;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata = '0;
    logic        av_waitrequest = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_set  = 0;

    always #5 clk = ~clk;

    filter_avalon_master dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_sample       (s_sample),
        .q_valid        (q_valid),
        .q_w            (q_w),
        .q_i            (q_i),
        .q_j            (q_j),
        .q_k            (q_k),
        .busy           (busy),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write       (av_write),
        .av_read        (av_read),
        .av_writedata   (av_writedata),
        .av_byteenable  (av_byteenable),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    function automatic logic [15:0] slave_val(input logic [15:0] a, input int set);
        if (a == 16'd72) return 16'hDEAD;
        if (set == 0) return (a == 16'd56) ? 16'h3C00 : 16'h0000;
        case (a)
            16'd56:  return 16'h1111;
            16'd60:  return 16'h2222;
            16'd64:  return 16'h3333;
            16'd68:  return 16'h4444;
            default: return 16'hBEEF;
        endcase
    endfunction

    // Read data appears only in the cycle after a completed read.
    always @(posedge clk) begin
        if (av_chipselect && av_read && !av_waitrequest)
            av_readdata <= {16'hFFFF, slave_val(av_address, rd_set)};
        else
            av_readdata <= 32'hBAD0_BAD0;
    end

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input logic wr, input logic rd,
                           input logic [15:0] a, input logic [15:0] d);
        logic cs;
        cs = wr | rd;
        if (cs) chk({tag, "_ctl"}, {13'b0, av_chipselect, av_write, av_read, av_address},
                    {13'b0, cs, wr, rd, a});
        else    chk({tag, "_ctl"}, {29'b0, av_chipselect, av_write, av_read}, 32'b0);
        if (wr) chk({tag, "_dat"}, av_writedata, {16'b0, d});
    endtask

    task automatic do_sample(input logic [95:0] smp, input int wait_run,
                             input logic [15:0] ew, input logic [15:0] ei,
                             input logic [15:0] ej, input logic [15:0] ek);
        int t0;
        s_valid  = 1'b1;
        s_sample = smp;
        chk("accept_ready", {31'b0, s_ready}, 32'd1);
        t0 = cyc;
        step;
        s_valid  = 1'b0;
        s_sample = ~smp;
        chk("busy_ready", {30'b0, busy, s_ready}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            chk_acc($sformatf("wr%0d", i), 1'b1, 1'b0, 16'(4 * i), smp[16*i +: 16]);
            step;
        end
        for (int j = 0; j < wait_run; j++) begin
            av_waitrequest = 1'b1;
            chk_acc($sformatf("run_wait%0d", j), 1'b1, 1'b0, 16'd76, 16'd1);
            step;
        end
        av_waitrequest = 1'b0;
        chk_acc("run", 1'b1, 1'b0, 16'd76, 16'd1);
        step;
        chk_acc("kick", 1'b0, 1'b1, 16'd72, 16'd0);
        step;
        for (int r = 0; r < 4; r++) begin
            chk_acc($sformatf("rd%0d", r), 1'b0, 1'b1, 16'(56 + 4 * r), 16'd0);
            step;
            chk_acc($sformatf("cap%0d", r), 1'b0, 1'b0, 16'd0, 16'd0);
            chk("cap_qv", {31'b0, q_valid}, 32'd0);
            step;
        end
        chk("q_valid", {31'b0, q_valid}, 32'd1);
        chk("latency", 32'(cyc - t0), 32'(17 + wait_run));
        chk("done_ready", {31'b0, s_ready}, 32'd1);
        chk("q_wi", {q_w, q_i}, {ew, ei});
        chk("q_jk", {q_j, q_k}, {ej, ek});
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        step;
        step;
        chk("rst_strobes", {29'b0, av_chipselect, av_write, av_read}, 32'd0);
        chk("rst_addr", {16'b0, av_address}, 32'd0);
        chk("rst_wdata", av_writedata, 32'd0);
        chk("rst_qv", {31'b0, q_valid}, 32'd0);
        chk("rst_qwi", {q_w, q_i}, 32'd0);
        chk("rst_qjk", {q_j, q_k}, 32'd0);
        chk("byteen", {28'b0, av_byteenable}, 32'hF);
        reset = 1'b0;
        chk("rst_ready", {30'b0, busy, s_ready}, 32'd1);

        rd_set = 0;
        do_sample({6{16'h3C00}}, 0, 16'h3C00, 16'h0000, 16'h0000, 16'h0000);
        step;
        chk("qv_pulse", {31'b0, q_valid}, 32'd0);
        step;
        step;
        chk("q_hold", {q_w, q_i}, {16'h3C00, 16'h0000});
        chk("idle_strobes", {29'b0, av_chipselect, av_write, av_read}, 32'd0);

        rd_set = 1;
        do_sample({16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001},
                  3, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step;

        rd_set = 0;
        do_sample({16'h0B06, 16'h0B05, 16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01},
                  0, 16'h3C00, 16'h0000, 16'h0000, 16'h0000);
        rd_set = 1;
        do_sample({16'h7C06, 16'h7C05, 16'h7C04, 16'h7C03, 16'h7C02, 16'h7C01},
                  0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step;
        chk("b2b_qv_pulse", {31'b0, q_valid}, 32'd0);

        s_valid  = 1'b1;
        s_sample = {6{16'h1234}};
        step;
        s_valid = 1'b0;
        for (int c = 1; c < 12; c++) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("mid_rst_strobes", {29'b0, av_chipselect, av_write, av_read}, 32'd0);
        chk("mid_rst_qwi", {q_w, q_i}, 32'd0);
        chk("mid_rst_qjk", {q_j, q_k}, 32'd0);
        chk("mid_rst_ready", {31'b0, s_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            seen = seen | q_valid | av_chipselect;
            step;
        end
        chk("mid_rst_quiet", {31'b0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
